spi_master: RTL and testbench



---
 rtl/spi_master.sv | 116 +++++++++++
 tb/tb_spi_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit frame per accepted start, MSB first.
// Every non-idle state is held for CLK_DIV clk cycles by a shared divider.
module spi_master #(
    parameter int CLK_DIV     = 4,
    parameter int DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] tx_data,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   busy,
    output logic                   done,
    output logic                   SCLK,
    output logic                   MOSI,
    output logic                   SS,
    input  logic                   MISO
);

    localparam int DIV_W = 8;
    localparam int CNT_W = $clog2(DATA_LENGTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t                 state_reg;
    logic [DIV_W-1:0]       div_cnt_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [CNT_W-1:0]       bit_cnt_next;
    logic [DATA_LENGTH-1:0] tx_shift_reg;
    logic [DATA_LENGTH-1:0] rx_shift_reg;
    logic                   div_tc;

    assign div_tc       = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign bit_cnt_next = bit_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            SCLK         <= 1'b0;
            MOSI         <= 1'b0;
            SS           <= 1'b1;
        end else begin
            done <= 1'b0;
            // The divider free-runs in every timed state and wraps on terminal count.
            if (state_reg != IDLE) begin
                div_cnt_reg <= div_tc ? '0 : div_cnt_reg + DIV_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        tx_shift_reg <= tx_data;
                        MOSI         <= tx_data[DATA_LENGTH-1];
                        SS           <= 1'b0;
                        busy         <= 1'b1;
                        bit_cnt_reg  <= '0;
                        div_cnt_reg  <= '0;
                        state_reg    <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (div_tc) begin
                        SCLK         <= 1'b1;
                        rx_shift_reg <= {rx_shift_reg[DATA_LENGTH-2:0], MISO};
                        state_reg    <= HIGH;
                    end
                end
                HIGH: begin
                    if (div_tc) begin
                        SCLK        <= 1'b0;
                        bit_cnt_reg <= bit_cnt_next;
                        if (bit_cnt_next == CNT_W'(DATA_LENGTH)) begin
                            state_reg <= HOLD;
                        end else begin
                            // Next bit goes out on the falling edge, a full LOW before the rise.
                            tx_shift_reg <= tx_shift_reg << 1;
                            MOSI         <= tx_shift_reg[DATA_LENGTH-2];
                            state_reg    <= LOW;
                        end
                    end
                end
                HOLD: begin
                    if (div_tc) begin
                        SS        <= 1'b1;
                        MOSI      <= 1'b0;
                        rx_data   <= rx_shift_reg;
                        done      <= 1'b1;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (div_tc) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master: a negedge monitor measures each
// frame and the results are compared against values derived from the frame rules.
module tb_spi_master;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       SCLK;
    logic       MOSI;
    logic       SS;
    logic       MISO;

    int checks = 0;
    int errors = 0;

    // MISO source: 0 loopback, 1 tied high, 2 tied low, 3 behavioural slave
    int         miso_mode = 0;
    logic       junk = 1'b0;
    logic       slave_miso = 1'b0;
    logic [7:0] slave_tx = 8'h00;
    logic [7:0] slave_rx_byte = 8'h00;

    always #5 clk = ~clk;

    assign MISO = SS ? junk :
                  (miso_mode == 0) ? MOSI :
                  (miso_mode == 1) ? 1'b1 :
                  (miso_mode == 2) ? 1'b0 : slave_miso;

    spi_master #(.CLK_DIV(CD), .DATA_LENGTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .SS      (SS),
        .MISO    (MISO)
    );

    // Mode-0 slave: presents MSB on SS fall, next bit after each SCLK fall,
    // captures MOSI on SCLK rise. Also randomises the bus value outside frames.
    int         s_idx = 0;
    logic [7:0] s_rx = 8'h00;
    logic       s_prev_ss = 1'b1;
    logic       s_prev_sclk = 1'b0;
    always @(negedge clk) begin
        junk = 1'($urandom);
        if (!SS) begin
            if (s_prev_ss) begin
                s_idx = 0;
                s_rx  = 8'h00;
            end else if (s_prev_sclk && !SCLK) begin
                s_idx++;
            end
            if (SCLK && !s_prev_sclk) s_rx = {s_rx[6:0], MOSI};
            slave_miso = (s_idx < 8) ? slave_tx[7 - s_idx] : 1'b0;
        end else if (!s_prev_ss) begin
            slave_rx_byte = s_rx;
        end
        s_prev_ss   = SS;
        s_prev_sclk = SCLK;
    end

    // Frame monitor
    int         m_cyc = 0;
    int         m_frames = 0;
    int         m_ss_cnt = 0, m_rises = 0, m_min_setup = 1000, m_mosi_stable = 0;
    logic [7:0] m_bits = 8'h00;
    int         m_last_ss_low = 0, m_last_rises = 0, m_last_min_setup = 0, m_last_gap = 0;
    logic [7:0] m_last_bits = 8'h00;
    int         m_ss_rise_cyc = 0;
    int         m_done_cnt = 0, m_done_cyc = 0, m_busy_fall_cyc = 0, m_rx_bad = 0;
    logic       m_busy_at_done = 1'b0;
    logic       m_prev_ss = 1'b1, m_prev_sclk = 1'b0, m_prev_mosi = 1'b0;
    logic       m_prev_busy = 1'b0, m_prev_rst = 1'b0;
    logic [7:0] m_prev_rx = 8'h00;
    always @(negedge clk) begin
        m_cyc++;
        if (MOSI !== m_prev_mosi) m_mosi_stable = 0;
        else if (m_mosi_stable < 1000) m_mosi_stable++;
        if (!SS) begin
            if (m_prev_ss) begin
                m_ss_cnt    = 0;
                m_rises     = 0;
                m_bits      = 8'h00;
                m_min_setup = 1000;
                m_last_gap  = m_cyc - m_ss_rise_cyc;
            end
            m_ss_cnt++;
            if (SCLK && !m_prev_sclk) begin
                m_rises++;
                m_bits = {m_bits[6:0], MOSI};
                if (m_mosi_stable < m_min_setup) m_min_setup = m_mosi_stable;
            end
        end else if (!m_prev_ss) begin
            m_last_ss_low    = m_ss_cnt;
            m_last_rises     = m_rises;
            m_last_bits      = m_bits;
            m_last_min_setup = m_min_setup;
            m_ss_rise_cyc    = m_cyc;
            m_frames++;
        end
        if (done) begin
            m_done_cnt++;
            m_done_cyc     = m_cyc;
            m_busy_at_done = busy;
        end
        if (!busy && m_prev_busy) m_busy_fall_cyc = m_cyc;
        if (rx_data !== m_prev_rx && !done && rst_n && m_prev_rst) m_rx_bad++;
        m_prev_ss   = SS;
        m_prev_sclk = SCLK;
        m_prev_mosi = MOSI;
        m_prev_busy = busy;
        m_prev_rst  = rst_n;
        m_prev_rx   = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte the master must receive, given what the MISO source presents
    function automatic logic [7:0] model_rx(input int mode, input logic [7:0] tx, input logic [7:0] sb);
        case (mode)
            0:       return tx;
            1:       return 8'hFF;
            2:       return 8'h00;
            default: return sb;
        endcase
    endfunction

    task automatic wait_busy_low(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_busy_release"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_frame_shape(input string tag, input logic [7:0] tx);
        check({tag, "_ss_low"}, m_last_ss_low, 17 * CD);
        check({tag, "_rises"}, m_last_rises, 8);
        check({tag, "_mosi_bits"}, 32'(m_last_bits), 32'(tx));
        check({tag, "_mosi_setup"}, 32'(m_last_min_setup >= CD), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] tx, input int mode, input logic [7:0] sb,
                             input bit poke, input int poke_at, input string tag);
        int f0, d0;
        bit ok;
        @(negedge clk);
        miso_mode = mode;
        slave_tx  = sb;
        f0        = m_frames;
        d0        = m_done_cnt;
        tx_data   = tx;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        tx_data = ~tx;
        ok      = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            start = (poke && c == poke_at);
            if (start) tx_data = 8'h00;
            if (m_frames != f0) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_frame_end"}, 32'(ok), 32'd1);
        wait_busy_low(tag);
        check_frame_shape(tag, tx);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(model_rx(mode, tx, sb)));
        check({tag, "_done_pulses"}, m_done_cnt - d0, 1);
        check({tag, "_busy_at_done"}, 32'(m_busy_at_done), 32'd1);
        check({tag, "_done_to_idle"}, m_busy_fall_cyc - m_done_cyc, CD);
        check({tag, "_rx_stable"}, m_rx_bad, 0);
        if (mode == 3) check({tag, "_slave_rx"}, 32'(slave_rx_byte), 32'(tx));
        $display("frame %s tx=%02h mode=%0d rx=%02h", tag, tx, mode, rx_data);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"}, 32'(SS), 32'd1);
        check({tag, "_sclk"}, 32'(SCLK), 32'd0);
        check({tag, "_mosi"}, 32'(MOSI), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rx"}, 32'(rx_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int         f0, d0, r;
        bit         ok;
        logic       ps;
        logic [7:0] rtx, rsb;
        int         rmode;

        rst_n   = 1'b0;
        start   = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(8'hA5, 0, 8'h00, 1'b0, 0, "loop_a5");
        run_frame(8'h3C, 1, 8'h00, 1'b0, 0, "tie1_3c");
        run_frame(8'h3C, 2, 8'h00, 1'b0, 0, "tie0_3c");
        run_frame(8'h96, 0, 8'h00, 1'b1, 10, "restart_ignored");

        // Abort mid-frame just after the fourth SCLK rise
        @(negedge clk);
        miso_mode = 0;
        tx_data   = 8'hA5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r     = 0;
        ps    = SCLK;
        ok    = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (SCLK && !ps) r++;
            ps = SCLK;
            if (r == 4) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_rise4", 32'(ok), 32'd1);
        d0    = m_done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", m_done_cnt - d0, 0);
        $display("abort at rise 4 done_pulses=%0d", m_done_cnt - d0);
        run_frame(8'h5A, 0, 8'h00, 1'b0, 0, "after_abort");

        // Back-to-back frames with start held high
        @(negedge clk);
        miso_mode = 0;
        f0        = m_frames;
        d0        = m_done_cnt;
        tx_data   = 8'h12;
        start     = 1'b1;
        ok        = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        tx_data = 8'h34;
        check("b2b_accept", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (m_frames != f0) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_first_end", 32'(ok), 32'd1);
        check("b2b_first_rx", 32'(rx_data), 32'h12);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!SS) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_start", 32'(ok), 32'd1);
        check("b2b_ss_high_gap", m_last_gap, CD + 1);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (m_frames == f0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_second_end", 32'(ok), 32'd1);
        wait_busy_low("b2b");
        check_frame_shape("b2b_second", 8'h34);
        check("b2b_second_rx", 32'(rx_data), 32'h34);
        check("b2b_done_pulses", m_done_cnt - d0, 2);
        $display("b2b gap=%0d rx=%02h", m_last_gap, rx_data);

        run_frame(8'h69, 3, 8'hC3, 1'b0, 0, "slave_1");
        run_frame(8'hE1, 3, 8'hC3, 1'b0, 0, "slave_2");

        for (int i = 0; i < 8; i++) begin
            rtx   = 8'($urandom);
            rsb   = 8'($urandom);
            rmode = int'($urandom_range(0, 3));
            run_frame(rtx, rmode, rsb, 1'($urandom), int'($urandom_range(1, 60)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
